vx_tex_req_sched: RTL

Multi-channel front-end scheduler for the texture unit. It merges NUM_REQS independent texture request channels (one per core/sub-core) onto the single request port of one texture unit, and routes responses back to the originating channel. It enforces a per-channel outstanding-request limit and supports a drain mode for context switch or reconfiguration. It sits between the cores' texture bus and the texture unit's request/response bus.

---
 rtl/vx_tex_req_sched_if.sv | 56 +++++
 rtl/vx_tex_req_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tex_req_sched_if.sv
// ---------------------------------------------------------------------------
// vx_tex_req_sched_if
//
// Request/response bus between the texture request scheduler and one
// texture unit.
//
//   tex_req_valid   scheduler -> unit   request valid
//   tex_req_data    scheduler -> unit   opaque request payload (DATAW)
//   tex_req_tag     scheduler -> unit   {requester tag, channel id} (TAGW)
//   tex_req_ready   unit -> scheduler   request accept
//   tex_rsp_valid   unit -> scheduler   response valid
//   tex_rsp_texels  unit -> scheduler   NUM_LANES x 32-bit texels
//   tex_rsp_tag     unit -> scheduler   returned {requester tag, channel id}
//   tex_rsp_ready   scheduler -> unit   response accept
//
// master: the scheduler side.  slave: the texture unit side.
// ---------------------------------------------------------------------------
interface vx_tex_req_sched_if #(
  parameter int DATAW     = 128,
  parameter int TAGW      = 10,
  parameter int NUM_LANES = 4
);

  logic                      tex_req_valid;
  logic [DATAW-1:0]          tex_req_data;
  logic [TAGW-1:0]           tex_req_tag;
  logic                      tex_req_ready;

  logic                      tex_rsp_valid;
  logic [NUM_LANES*32-1:0]   tex_rsp_texels;
  logic [TAGW-1:0]           tex_rsp_tag;
  logic                      tex_rsp_ready;

  modport master (
    output tex_req_valid,
    output tex_req_data,
    output tex_req_tag,
    input  tex_req_ready,
    input  tex_rsp_valid,
    input  tex_rsp_texels,
    input  tex_rsp_tag,
    output tex_rsp_ready
  );

  modport slave (
    input  tex_req_valid,
    input  tex_req_data,
    input  tex_req_tag,
    output tex_req_ready,
    output tex_rsp_valid,
    output tex_rsp_texels,
    output tex_rsp_tag,
    input  tex_rsp_ready
  );

endinterface

// File: rtl/vx_tex_req_sched.sv
// ---------------------------------------------------------------------------
// vx_tex_req_sched
//
// Front-end scheduler for one texture unit. Merges NUM_REQS requester
// channels onto the single texture request port with round-robin
// arbitration, limits outstanding requests per channel, and steers
// responses back to the originating channel by the channel id carried in
// the low bits of the tag.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid/data/tag   per-channel request inputs (packed, channel 0 low)
//   req_ready            per-channel accept (at most one high per cycle)
//   tex_bus              texture unit request/response bus (master side)
//   rsp_valid/texels/tag per-channel response outputs (packed)
//   rsp_ready            per-channel response accept
//   drain                level input; blocks new request accepts
//   idle                 registered: nothing pending, nothing buffered
//   perf_stall_cycles    wrapping count of cycles with a stalled requester
// ---------------------------------------------------------------------------
module vx_tex_req_sched #(
  parameter int NUM_REQS      = 4,
  parameter int NUM_LANES     = 4,
  parameter int DATAW         = 128,
  parameter int TAG_WIDTH     = 8,
  parameter int MAX_PENDING   = 8,
  parameter int PERF_CTR_BITS = 32
) (
  input  logic                                clk,
  input  logic                                reset,

  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS*DATAW-1:0]           req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]       req_tag,
  output logic [NUM_REQS-1:0]                 req_ready,

  vx_tex_req_sched_if.master                  tex_bus,

  output logic [NUM_REQS-1:0]                 rsp_valid,
  output logic [NUM_REQS*NUM_LANES*32-1:0]    rsp_texels,
  output logic [NUM_REQS*TAG_WIDTH-1:0]       rsp_tag,
  input  logic [NUM_REQS-1:0]                 rsp_ready,

  input  logic                                drain,
  output logic                                idle,
  output logic [PERF_CTR_BITS-1:0]            perf_stall_cycles
);

  localparam int CH_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);
  localparam int TEXW    = NUM_LANES * 32;
  localparam int XTAGW   = TAG_WIDTH + CH_BITS;

  // Channel indices are handled one bit wider so the modulo wrap and the
  // legality check are not constant comparisons for power-of-two NUM_REQS.
  localparam logic [CH_BITS:0]    NUM_REQS_X = (CH_BITS+1)'(NUM_REQS);
  localparam logic [CH_BITS:0]    CH_ONE_X   = (CH_BITS+1)'(1);
  localparam logic [PEND_W-1:0]   MAX_PEND_P = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0]   PEND_ONE   = PEND_W'(1);
  localparam logic [PERF_CTR_BITS-1:0] PERF_ONE = PERF_CTR_BITS'(1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CH_BITS-1:0]   rr_ptr;
  logic [PEND_W-1:0]    pending      [NUM_REQS];
  logic [PEND_W-1:0]    pending_next [NUM_REQS];

  logic                 out_valid;
  logic                 out_valid_next;
  logic [DATAW-1:0]     out_data;
  logic [XTAGW-1:0]     out_tag;

  logic [NUM_REQS-1:0]  rsp_valid_next;
  logic                 idle_next;

  // ---------------------------------------------------------------------
  // Request side: eligibility, round-robin grant, output register
  // ---------------------------------------------------------------------
  logic [NUM_REQS-1:0]  eligible;
  logic                 grant_found;
  logic [CH_BITS-1:0]   grant_idx;
  logic [CH_BITS:0]     scan_idx;
  logic [CH_BITS:0]     ptr_inc;
  logic [CH_BITS-1:0]   ptr_next;
  logic                 out_free;
  logic                 accept;
  logic [DATAW-1:0]     sel_data;
  logic [TAG_WIDTH-1:0] sel_tag;

  // Reset is folded into eligibility so no request is granted while the
  // block is being reset.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (pending[i] < MAX_PEND_P) && !drain && !reset;
    end
  end

  // Search starts at rr_ptr and wraps; the first eligible channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan_idx = {1'b0, rr_ptr} + (CH_BITS+1)'(k);
      if (scan_idx >= NUM_REQS_X) begin
        scan_idx = scan_idx - NUM_REQS_X;
      end
      if (!grant_found && eligible[scan_idx[CH_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CH_BITS-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant_idx} + CH_ONE_X;
    ptr_next = (ptr_inc >= NUM_REQS_X) ? '0 : ptr_inc[CH_BITS-1:0];
  end

  // The single output slot can take a new entry when empty or when its
  // current entry leaves this cycle.
  assign out_free = !out_valid || tex_bus.tex_req_ready;
  assign accept   = grant_found && out_free;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == CH_BITS'(i)) begin
        sel_data = req_data[i*DATAW +: DATAW];
        sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid;
    if (accept) begin
      out_valid_next = 1'b1;
    end else if (tex_bus.tex_req_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // Data and tag only change on accept, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= out_valid_next;
      if (accept) begin
        out_data <= sel_data;
        out_tag  <= {sel_tag, grant_idx};
        rr_ptr   <= ptr_next;
      end
    end
  end

  assign tex_bus.tex_req_valid = out_valid;
  assign tex_bus.tex_req_data  = out_data;
  assign tex_bus.tex_req_tag   = out_tag;

  // ---------------------------------------------------------------------
  // Response side: demux by channel id into 1-deep per-channel registers
  // ---------------------------------------------------------------------
  logic [CH_BITS-1:0]   rsp_ch;
  logic                 rsp_ch_legal;
  logic                 rsp_accept_ok;
  logic                 rsp_fire;
  logic [NUM_REQS-1:0]  rsp_load;
  logic [NUM_REQS-1:0]  rsp_take;

  assign rsp_ch       = tex_bus.tex_rsp_tag[CH_BITS-1:0];
  assign rsp_ch_legal = ({1'b0, rsp_ch} < NUM_REQS_X);

  // An out-of-range channel matches no register, so it is accepted and
  // dropped. A held register may refill in the cycle it is being consumed.
  always_comb begin
    rsp_accept_ok = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_ch == CH_BITS'(i)) begin
        rsp_accept_ok = !rsp_valid[i] || rsp_ready[i];
      end
    end
    if (reset) begin
      rsp_accept_ok = 1'b0;
    end
  end

  assign tex_bus.tex_rsp_ready = rsp_accept_ok;
  assign rsp_fire = tex_bus.tex_rsp_valid && rsp_accept_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_load[i]       = rsp_fire && (rsp_ch == CH_BITS'(i));
      rsp_take[i]       = rsp_valid[i] && rsp_ready[i];
      rsp_valid_next[i] = rsp_load[i] ? 1'b1 : (rsp_ready[i] ? 1'b0 : rsp_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_texels <= '0;
      rsp_tag    <= '0;
    end else begin
      rsp_valid <= rsp_valid_next;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (rsp_load[i]) begin
          rsp_texels[i*TEXW +: TEXW]           <= tex_bus.tex_rsp_texels;
          rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]    <= tex_bus.tex_rsp_tag[XTAGW-1:CH_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tex_bus.tex_rsp_valid) begin
      assert (rsp_ch_legal);
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel outstanding counters
  // ---------------------------------------------------------------------
  // Simultaneous accept and consume cancel out. Decrement at zero is held
  // at zero so responses arriving after a reset cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      pending_next[i] = pending[i];
      if (req_ready[i] && !rsp_take[i]) begin
        pending_next[i] = pending[i] + PEND_ONE;
      end else if (rsp_take[i] && !req_ready[i] && (pending[i] != '0)) begin
        pending_next[i] = pending[i] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pending[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pending[i] <= pending_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Idle flag and stall counter
  // ---------------------------------------------------------------------
  // Idle is built from next-state values so it reflects the state the
  // block holds in the same cycle the flag is visible.
  always_comb begin
    idle_next = !out_valid_next && (rsp_valid_next == '0);
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pending_next[i] != '0) begin
        idle_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle              <= 1'b1;
      perf_stall_cycles <= '0;
    end else begin
      idle <= idle_next;
      if (|(req_valid & ~req_ready)) begin
        perf_stall_cycles <= perf_stall_cycles + PERF_ONE;
      end
    end
  end

endmodule
